// File: rtl/frog_hop_controller.sv
// Frog movement: turns four direction buttons into grid hops that are
// animated in STEP_PX pixel steps, with hold-to-repeat and respawn.
// Ports:
//   i_Clk, i_Reset        clock, synchronous active-high reset
//   i_Frog_Up/Dn/Lt/Rt    debounced buttons, active high
//   i_Move_En             allows a new hop to start
//   i_Respawn             return to the start cell
//   o_Frog_Col/Row        committed cell
//   o_Frog_X/Y            animated sprite top-left pixel
//   o_Moving              hop in progress
//   o_Hop_Done            one-cycle pulse when a hop completes
//   o_Reached_Top         one-cycle pulse when a hop lands in row 0
module frog_hop_controller #(
   parameter int TILE_SIZE     = 32,
   parameter int GRID_COLS     = 20,
   parameter int GRID_ROWS     = 15,
   parameter int START_COL     = 10,
   parameter int START_ROW     = 14,
   parameter int STEP_PX       = 8,
   parameter int STEP_CYCLES   = 250000,
   parameter int REPEAT_CYCLES = 6250000,
   parameter int COL_W         = $clog2(GRID_COLS),
   parameter int ROW_W         = $clog2(GRID_ROWS),
   parameter int PIX_W         = 10
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic             i_Frog_Up,
   input  logic             i_Frog_Dn,
   input  logic             i_Frog_Lt,
   input  logic             i_Frog_Rt,
   input  logic             i_Move_En,
   input  logic             i_Respawn,
   output logic [COL_W-1:0] o_Frog_Col,
   output logic [ROW_W-1:0] o_Frog_Row,
   output logic [PIX_W-1:0] o_Frog_X,
   output logic [PIX_W-1:0] o_Frog_Y,
   output logic             o_Moving,
   output logic             o_Hop_Done,
   output logic             o_Reached_Top
);

   localparam int SC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int RC_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

   localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEP_CYCLES - 1);
   localparam logic [RC_W-1:0] REP_LAST  = RC_W'(REPEAT_CYCLES - 1);

   localparam logic [COL_W-1:0] COL_START = COL_W'(START_COL);
   localparam logic [ROW_W-1:0] ROW_START = ROW_W'(START_ROW);
   localparam logic [COL_W-1:0] COL_MAX   = COL_W'(GRID_COLS - 1);
   localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(GRID_ROWS - 1);

   localparam logic [PIX_W-1:0] X_START = PIX_W'(START_COL * TILE_SIZE);
   localparam logic [PIX_W-1:0] Y_START = PIX_W'(START_ROW * TILE_SIZE);
   localparam logic [PIX_W-1:0] STEP    = PIX_W'(STEP_PX);
   localparam logic [PIX_W-1:0] TILE    = PIX_W'(TILE_SIZE);

   typedef enum logic [1:0] {
      IDLE,
      HOP,
      HOLD,
      RELEASE
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       btn_q, btn_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [PIX_W-1:0] x_q, x_d;
   logic [PIX_W-1:0] y_q, y_d;
   logic [SC_W-1:0]  step_cnt_q, step_cnt_d;
   logic [RC_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic             hop_done_q, hop_done_d;
   logic             top_q, top_d;

   // Button vector order is {up, dn, lt, rt}
   logic [3:0]       btn;
   logic             one_hot;
   logic             legal;
   logic             req_ok;

   logic [PIX_W-1:0] cell_x;
   logic [PIX_W-1:0] cell_y;
   logic [PIX_W-1:0] x_step;
   logic [PIX_W-1:0] y_step;
   logic [COL_W-1:0] col_nxt;
   logic [ROW_W-1:0] row_nxt;
   logic             landed;

   assign btn = {i_Frog_Up, i_Frog_Dn, i_Frog_Lt, i_Frog_Rt};

   // Exactly one button: a true population-count-of-one test
   assign one_hot = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);

   assign legal = (btn[3] && (row_q != '0))
               || (btn[2] && (row_q != ROW_MAX))
               || (btn[1] && (col_q != '0))
               || (btn[0] && (col_q != COL_MAX));

   assign req_ok = one_hot && legal && i_Move_En;

   assign cell_x = PIX_W'(col_q) * TILE;
   assign cell_y = PIX_W'(row_q) * TILE;

   // One animation step toward the latched direction; the hop is over
   // when the stepped position equals the neighbouring cell's origin.
   always_comb begin
      x_step  = x_q;
      y_step  = y_q;
      col_nxt = col_q;
      row_nxt = row_q;
      landed  = 1'b0;
      unique case (1'b1)
         btn_q[3]: begin
            y_step  = y_q - STEP;
            row_nxt = row_q - ROW_W'(1);
            landed  = (y_step == cell_y - TILE);
         end
         btn_q[2]: begin
            y_step  = y_q + STEP;
            row_nxt = row_q + ROW_W'(1);
            landed  = (y_step == cell_y + TILE);
         end
         btn_q[1]: begin
            x_step  = x_q - STEP;
            col_nxt = col_q - COL_W'(1);
            landed  = (x_step == cell_x - TILE);
         end
         btn_q[0]: begin
            x_step  = x_q + STEP;
            col_nxt = col_q + COL_W'(1);
            landed  = (x_step == cell_x + TILE);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      btn_d      = btn_q;
      col_d      = col_q;
      row_d      = row_q;
      x_d        = x_q;
      y_d        = y_q;
      step_cnt_d = step_cnt_q;
      hold_cnt_d = hold_cnt_q;
      hop_done_d = 1'b0;
      top_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_ok) begin
               btn_d      = btn;
               step_cnt_d = '0;
               state_d    = HOP;
            end
         end
         HOP: begin
            if (step_cnt_q == STEP_LAST) begin
               step_cnt_d = '0;
               x_d        = x_step;
               y_d        = y_step;
               if (landed) begin
                  col_d      = col_nxt;
                  row_d      = row_nxt;
                  hop_done_d = 1'b1;
                  top_d      = (row_nxt == '0);
                  hold_cnt_d = '0;
                  state_d    = HOLD;
               end
            end else begin
               step_cnt_d = step_cnt_q + SC_W'(1);
            end
         end
         HOLD: begin
            if (btn == 4'd0) begin
               hold_cnt_d = '0;
               state_d    = IDLE;
            end else if (btn != btn_q) begin
               hold_cnt_d = '0;
               state_d    = RELEASE;
            end else if (hold_cnt_q == REP_LAST) begin
               // Blocked repeats leave the counter parked at its last value
               if (req_ok) begin
                  hold_cnt_d = '0;
                  step_cnt_d = '0;
                  state_d    = HOP;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + RC_W'(1);
            end
         end
         RELEASE: begin
            if (btn == 4'd0) begin
               state_d = IDLE;
            end
         end
         default: state_d = RELEASE;
      endcase

      if (i_Respawn) begin
         state_d    = RELEASE;
         col_d      = COL_START;
         row_d      = ROW_START;
         x_d        = X_START;
         y_d        = Y_START;
         step_cnt_d = '0;
         hold_cnt_d = '0;
         hop_done_d = 1'b0;
         top_d      = 1'b0;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q    <= RELEASE;
         btn_q      <= 4'd0;
         col_q      <= COL_START;
         row_q      <= ROW_START;
         x_q        <= X_START;
         y_q        <= Y_START;
         step_cnt_q <= '0;
         hold_cnt_q <= '0;
         hop_done_q <= 1'b0;
         top_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         btn_q      <= btn_d;
         col_q      <= col_d;
         row_q      <= row_d;
         x_q        <= x_d;
         y_q        <= y_d;
         step_cnt_q <= step_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         hop_done_q <= hop_done_d;
         top_q      <= top_d;
      end
   end

   assign o_Frog_Col    = col_q;
   assign o_Frog_Row    = row_q;
   assign o_Frog_X      = x_q;
   assign o_Frog_Y      = y_q;
   assign o_Moving      = (state_q == HOP);
   assign o_Hop_Done    = hop_done_q;
   assign o_Reached_Top = top_q;

endmodule

// File: tb/tb_frog_hop_controller.sv
// Directed bench for frog_hop_controller with short step/repeat timing.
// Hand-computed positions, pulse timing, boundaries, repeat and respawn.
module tb_frog_hop_controller;

   localparam logic [3:0] UP = 4'b1000;
   localparam logic [3:0] DN = 4'b0100;
   localparam logic [3:0] LT = 4'b0010;
   localparam logic [3:0] RT = 4'b0001;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn;
   logic       men;
   logic       resp;
   logic [4:0] col;
   logic [3:0] row;
   logic [9:0] px;
   logic [9:0] py;
   logic       moving;
   logic       done;
   logic       top;

   int n_checks = 0;
   int n_errors = 0;

   frog_hop_controller #(
      .TILE_SIZE    (32),
      .GRID_COLS    (20),
      .GRID_ROWS    (15),
      .START_COL    (10),
      .START_ROW    (14),
      .STEP_PX      (8),
      .STEP_CYCLES  (4),
      .REPEAT_CYCLES(20),
      .PIX_W        (10)
   ) dut (
      .i_Clk        (clk),
      .i_Reset      (rst),
      .i_Frog_Up    (btn[3]),
      .i_Frog_Dn    (btn[2]),
      .i_Frog_Lt    (btn[1]),
      .i_Frog_Rt    (btn[0]),
      .i_Move_En    (men),
      .i_Respawn    (resp),
      .o_Frog_Col   (col),
      .o_Frog_Row   (row),
      .o_Frog_X     (px),
      .o_Frog_Y     (py),
      .o_Moving     (moving),
      .o_Hop_Done   (done),
      .o_Reached_Top(top)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic watch(input int n, output int mv, output int dn);
      mv = 0;
      dn = 0;
      repeat (n) begin
         tick();
         if (moving) mv++;
         if (done) dn++;
      end
   endtask

   // One-cycle press, then run to the completion cycle and one more
   task automatic do_hop(input logic [3:0] b, output logic d,
                         output logic t);
      btn = b;
      tick();
      btn = 4'd0;
      repeat (16) tick();
      d = done;
      t = top;
      tick();
   endtask

   int   mv, dn;
   logic d, t;
   int   nd;
   int   times [8];

   initial begin
      rst  = 1'b1;
      btn  = 4'd0;
      men  = 1'b1;
      resp = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      // 1: reset state
      check("rst_col", col, 10);
      check("rst_row", row, 14);
      check("rst_x", px, 320);
      check("rst_y", py, 448);
      check("rst_moving", moving, 0);
      check("rst_done", done, 0);
      check("rst_top", top, 0);
      tick();

      // 3a: Dn at bottom row is a no-op
      btn = DN;
      watch(6, mv, dn);
      btn = 4'd0;
      check("dn_bottom_mv", mv, 0);
      check("dn_bottom_dn", dn, 0);
      check("dn_bottom_row", row, 14);

      // Move disabled blocks a legal press
      men = 1'b0;
      btn = UP;
      watch(5, mv, dn);
      btn = 4'd0;
      men = 1'b1;
      check("men_off_mv", mv, 0);
      check("men_off_row", row, 14);
      tick();

      // 2: single Up hop, 16 cycles from HOP entry
      btn = UP;
      tick();
      check("up_moving", moving, 1);
      btn = 4'd0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 4) check("up_y4", py, 440);
         if (i == 8) check("up_y8", py, 432);
         if (i == 12) check("up_y12", py, 424);
         if (i == 15) begin
            check("up_done15", done, 0);
            check("up_row15", row, 14);
         end
         if (i == 16) begin
            check("up_y16", py, 416);
            check("up_done16", done, 1);
            check("up_row16", row, 13);
            check("up_top16", top, 0);
         end
      end
      tick();
      check("up_after_mv", moving, 0);
      check("up_after_dn", done, 0);

      // 3b: Lt to column 0, then Lt again is refused
      for (int i = 0; i < 10; i++) do_hop(LT, d, t);
      check("lt_col0", col, 0);
      check("lt_x0", px, 0);
      btn = LT;
      watch(20, mv, dn);
      btn = 4'd0;
      check("lt_edge_mv", mv, 0);
      check("lt_edge_dn", dn, 0);
      check("lt_edge_col", col, 0);

      // 3c: two buttons together are ignored
      btn = UP | RT;
      watch(20, mv, dn);
      btn = 4'd0;
      check("dual_mv", mv, 0);
      check("dual_row", row, 13);
      check("dual_col", col, 0);

      // Respawn back to start
      resp = 1'b1;
      tick();
      resp = 1'b0;
      check("resp1_col", col, 10);
      check("resp1_row", row, 14);
      check("resp1_x", px, 320);
      check("resp1_y", py, 448);
      tick();

      // 4: Rt held 100 cycles -> completes at 16, 52, 88
      nd = 0;
      btn = RT;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (done) begin
            if (nd < 8) times[nd] = i - 1;
            nd++;
         end
      end
      check("rep_count", nd, 3);
      check("rep_t0", times[0], 16);
      check("rep_t1", times[1], 52);
      check("rep_t2", times[2], 88);
      check("rep_col", col, 13);
      check("rep_x", px, 416);
      btn = 4'd0;
      tick();
      btn = DN;
      watch(10, mv, dn);
      btn = 4'd0;
      check("rep_dn_mv", mv, 0);
      check("rep_dn_row", row, 14);
      tick();

      // 5: respawn mid-hop with Up still held
      btn = UP;
      tick();
      check("rsp_moving", moving, 1);
      repeat (8) tick();
      check("rsp_y8", py, 432);
      resp = 1'b1;
      tick();
      resp = 1'b0;
      check("rsp_x", px, 320);
      check("rsp_y", py, 448);
      check("rsp_row", row, 14);
      check("rsp_col", col, 10);
      check("rsp_mv", moving, 0);
      check("rsp_dn", done, 0);
      watch(40, mv, dn);
      check("rsp_held_mv", mv, 0);
      check("rsp_held_dn", dn, 0);
      btn = 4'd0;
      tick();
      tick();
      do_hop(UP, d, t);
      check("rsp_again_dn", d, 1);
      check("rsp_again_row", row, 13);

      // 6: climb to row 1, then into row 0
      for (int i = 0; i < 12; i++) do_hop(UP, d, t);
      check("climb_top_r1", t, 0);
      check("climb_row1", row, 1);
      check("climb_y1", py, 32);
      do_hop(UP, d, t);
      check("top_done", d, 1);
      check("top_pulse", t, 1);
      check("top_row0", row, 0);
      check("top_y0", py, 0);
      check("top_cleared", top, 0);
      btn = UP;
      watch(20, mv, dn);
      btn = 4'd0;
      check("top_up_mv", mv, 0);
      check("top_up_row", row, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
